// File: rtl/wshb_arbiter.sv
// Round-robin Wishbone arbiter: NB_MASTERS masters share one slave port.
// Ownership lasts for a whole m_cyc, so bursts are never split. Between two
// owners there is always one idle cycle. An optional watchdog answers a
// stalled transfer with m_err.
module wshb_arbiter #(
  parameter int unsigned NB_MASTERS = 2,
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NB_MASTERS-1:0]               m_cyc,
  input  logic [NB_MASTERS-1:0]               m_stb,
  input  logic [NB_MASTERS-1:0]               m_we,
  input  logic [32*NB_MASTERS-1:0]            m_adr,
  input  logic [8*DATA_BYTES*NB_MASTERS-1:0]  m_dat_ms,
  input  logic [DATA_BYTES*NB_MASTERS-1:0]    m_sel,
  input  logic [3*NB_MASTERS-1:0]             m_cti,
  input  logic [2*NB_MASTERS-1:0]             m_bte,
  output logic [NB_MASTERS-1:0]               m_ack,
  output logic [NB_MASTERS-1:0]               m_err,
  output logic [NB_MASTERS-1:0]               m_rty,
  output logic [8*DATA_BYTES-1:0]             m_dat_sm,
  output logic                                s_cyc,
  output logic                                s_stb,
  output logic                                s_we,
  output logic [31:0]                         s_adr,
  output logic [8*DATA_BYTES-1:0]             s_dat_ms,
  output logic [DATA_BYTES-1:0]               s_sel,
  output logic [2:0]                          s_cti,
  output logic [1:0]                          s_bte,
  input  logic                                s_ack,
  input  logic                                s_err,
  input  logic                                s_rty,
  input  logic [8*DATA_BYTES-1:0]             s_dat_sm,
  output logic [NB_MASTERS-1:0]               grant
);

  localparam int unsigned IdxW = $clog2(NB_MASTERS);
  localparam int unsigned DatW = 8 * DATA_BYTES;
  // Watchdog is at least 8 bits wide, wider only if TIMEOUT needs it.
  localparam int unsigned WdW  = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NB_MASTERS - 1);

  typedef enum logic {StIdle, StOwned} state_e;

  state_e          state_q, state_d;
  // last_q doubles as the owner index while in StOwned.
  logic [IdxW-1:0] last_q, last_d;
  logic [WdW-1:0]  wdog_q, wdog_d;

  logic [IdxW-1:0] pick;
  logic [IdxW-1:0] cand;
  logic            found;
  logic            wdog_fire;
  logic            stalled;

  assign m_dat_sm = s_dat_sm;

  // Round-robin search starting just above the previous owner.
  always_comb begin
    pick  = last_q;
    cand  = last_q;
    found = 1'b0;
    for (int unsigned k = 1; k <= NB_MASTERS; k++) begin
      cand = IdxW'((32'(last_q) + k) % NB_MASTERS);
      if (!found && m_cyc[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // State, owner and watchdog registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= LastIdx;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  // Next-state: grant on any request, release when the owner drops cyc.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StOwned;
          last_d  = pick;
        end
      end
      StOwned: begin
        if (!m_cyc[last_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign wdog_fire = (TIMEOUT != 0) && (state_q == StOwned) && (wdog_q == WdLimit);
  assign stalled   = s_stb && !s_ack && !s_err && !s_rty;

  // Watchdog counts consecutive stalled strobes of the current owner.
  always_comb begin
    wdog_d = '0;
    if ((TIMEOUT != 0) && (state_q == StOwned) && (state_d == StOwned) &&
        !wdog_fire && stalled) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  // Outputs: route the owner's bus to the slave and responses back.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = '0;
    s_bte    = '0;
    m_ack    = '0;
    m_err    = '0;
    m_rty    = '0;
    grant    = '0;
    if (state_q == StOwned) begin
      grant         = NB_MASTERS'(1) << last_q;
      s_cyc         = m_cyc[last_q];
      s_stb         = m_stb[last_q];
      s_we          = m_we[last_q];
      s_adr         = m_adr[32*last_q +: 32];
      s_dat_ms      = m_dat_ms[DatW*last_q +: DatW];
      s_sel         = m_sel[DATA_BYTES*last_q +: DATA_BYTES];
      s_cti         = m_cti[3*last_q +: 3];
      s_bte         = m_bte[2*last_q +: 2];
      // A watchdog error replaces whatever the slave says this cycle.
      m_ack[last_q] = s_ack && !wdog_fire;
      m_err[last_q] = s_err || wdog_fire;
      m_rty[last_q] = s_rty && !wdog_fire;
    end
  end

endmodule

// File: tb/tb_wshb_arbiter.sv
// Random multi-master traffic against wshb_arbiter; a queue-based reference
// model predicts every owned cycle and a monitor compares DUT outputs.
module tb_wshb_arbiter;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int DW = 8 * DB;
  localparam int T  = 8;
  localparam int NormCycles  = 1500;
  localparam int StallCycles = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N-1:0]      m_cyc, m_stb, m_we;
  logic [32*N-1:0]   m_adr;
  logic [DW*N-1:0]   m_dat_ms;
  logic [DB*N-1:0]   m_sel;
  logic [3*N-1:0]    m_cti;
  logic [2*N-1:0]    m_bte;
  logic              s_ack, s_err, s_rty;
  logic [DW-1:0]     s_dat_sm;

  logic [N-1:0]      m_ack, m_err, m_rty, grant;
  logic [DW-1:0]     m_dat_sm, s_dat_ms;
  logic              s_cyc, s_stb, s_we;
  logic [31:0]       s_adr;
  logic [DB-1:0]     s_sel;
  logic [2:0]        s_cti;
  logic [1:0]        s_bte;

  logic [N-1:0]      m_ack_z, m_err_z, m_rty_z, grant_z;
  logic [DW-1:0]     m_dat_sm_z, s_dat_ms_z;
  logic              s_cyc_z, s_stb_z, s_we_z;
  logic [31:0]       s_adr_z;
  logic [DB-1:0]     s_sel_z;
  logic [2:0]        s_cti_z;
  logic [1:0]        s_bte_z;

  always #5 clk = ~clk;

  wshb_arbiter #(.NB_MASTERS(N), .DATA_BYTES(DB), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_dat_ms(m_dat_ms), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte), .m_ack(m_ack),
    .m_err(m_err), .m_rty(m_rty), .m_dat_sm(m_dat_sm), .s_cyc(s_cyc), .s_stb(s_stb),
    .s_we(s_we), .s_adr(s_adr), .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti),
    .s_bte(s_bte), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_sm(s_dat_sm),
    .grant(grant)
  );

  // Second instance with the watchdog disabled, fed the same stimulus.
  wshb_arbiter #(.NB_MASTERS(N), .DATA_BYTES(DB), .TIMEOUT(0)) dut_nowd (
    .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_dat_ms(m_dat_ms), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte), .m_ack(m_ack_z),
    .m_err(m_err_z), .m_rty(m_rty_z), .m_dat_sm(m_dat_sm_z), .s_cyc(s_cyc_z),
    .s_stb(s_stb_z), .s_we(s_we_z), .s_adr(s_adr_z), .s_dat_ms(s_dat_ms_z),
    .s_sel(s_sel_z), .s_cti(s_cti_z), .s_bte(s_bte_z), .s_ack(s_ack), .s_err(s_err),
    .s_rty(s_rty), .s_dat_sm(s_dat_sm), .grant(grant_z)
  );

  typedef struct {
    int                tag;
    logic [N-1:0]      grant;
    logic [75:0]       slv;
    logic [3*N+DW-1:0] rsp;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;
  bit   mon_en = 1'b0;
  bit   done   = 1'b0;

  // Reference model: owner (-1 = none), previous grantee, stalled-run length.
  int mo_owner = -1;
  int mo_last  = N - 1;
  int mo_run   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", name, cycle, got, exp);
    end
  endtask

  // Advance the model across a clock edge using the pre-edge inputs.
  task automatic model_edge();
    if (rst) begin
      mo_owner = -1;
      mo_last  = N - 1;
      mo_run   = 0;
    end else if (mo_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (mo_owner < 0 && m_cyc[(mo_last + k) % N]) begin
          mo_owner = (mo_last + k) % N;
        end
      end
      if (mo_owner >= 0) mo_last = mo_owner;
      mo_run = 0;
    end else if (!m_cyc[mo_owner]) begin
      mo_owner = -1;
      mo_run   = 0;
    end else if (mo_run == T) begin
      mo_run = 0;
    end else if (m_stb[mo_owner] && !(s_ack || s_err || s_rty)) begin
      mo_run++;
    end else begin
      mo_run = 0;
    end
  endtask

  // Predict this cycle's outputs from the model and the current inputs.
  task automatic push_expect();
    exp_t        e;
    int          o;
    bit          fire;
    logic [N-1:0] one, ack, err, rty;
    if (mo_owner < 0) return;
    o    = mo_owner;
    fire = (mo_run == T);
    one  = N'(1) << o;
    ack  = (!fire && s_ack) ? one : '0;
    err  = (fire || s_err) ? one : '0;
    rty  = (!fire && s_rty) ? one : '0;
    e.tag   = cycle;
    e.grant = one;
    e.slv   = {m_cyc[o], m_stb[o], m_we[o], m_adr[32*o +: 32], m_dat_ms[DW*o +: DW],
               m_sel[DB*o +: DB], m_cti[3*o +: 3], m_bte[2*o +: 2]};
    e.rsp   = {ack, err, rty, s_dat_sm};
    q.push_back(e);
  endtask

  int           beats[N];
  logic [N-1:0] seen;
  int           stall_left = 0;
  int           nowd_errs  = 0;

  task automatic new_beat(input int i);
    m_adr[32*i +: 32]    = $urandom;
    m_dat_ms[DW*i +: DW] = $urandom;
    m_sel[DB*i +: DB]    = DB'($urandom);
    m_we[i]              = 1'($urandom);
    m_stb[i]             = ($urandom_range(0, 7) != 0);
    m_cti[3*i +: 3]      = (beats[i] == 1) ? 3'b111 : 3'b010;
  endtask

  // Stimulus: master and slave behaviour plus model prediction.
  initial begin
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_ms = '0;
    m_sel = '0; m_cti = '0; m_bte = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat_sm = '0;
    seen = '0;
    for (int i = 0; i < N; i++) beats[i] = 0;
    for (int c = 0; c < NormCycles + StallCycles; c++) begin
      @(posedge clk);
      model_edge();
      cycle++;
      #1;
      if (c == 0) begin
        mon_en = 1'b1;
        check("reset_grant", grant, '0);
        check("reset_s_cyc", {s_cyc, s_stb, s_cyc_z, grant_z}, '0);
      end
      rst = (c < 2) || (c >= 10 && c < NormCycles && $urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        if (beats[i] > 0 && seen[i]) begin
          beats[i]--;
          if (beats[i] == 0) begin
            m_cyc[i] = 1'b0;
            m_stb[i] = 1'b0;
          end else begin
            new_beat(i);
          end
        end else if (beats[i] > 0) begin
          m_stb[i] = m_stb[i] || ($urandom_range(0, 3) == 0);
        end else if ((c == 3 && (i == 0 || i == 2)) ||
                     (c > 3 && $urandom_range(0, 3) == 0)) begin
          beats[i] = $urandom_range(1, 4);
          m_cyc[i] = 1'b1;
          m_bte[2*i +: 2] = 2'b00;
          new_beat(i);
        end
      end
      s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
      if (c < NormCycles) begin
        if (stall_left > 0) begin
          stall_left--;
        end else if ($urandom_range(0, 29) == 0) begin
          stall_left = $urandom_range(5, 15);
        end else begin
          case ($urandom_range(0, 7))
            3, 4, 5: s_ack = 1'b1;
            6:       s_err = 1'b1;
            7:       s_rty = 1'b1;
            default: ;
          endcase
        end
      end
      s_dat_sm = $urandom;
      push_expect();
      @(negedge clk);
      seen = m_ack | m_err | m_rty;
      if (c >= NormCycles && (|m_err_z)) nowd_errs++;
    end
    done = 1'b1;
    #2;
    check("no_watchdog_err", nowd_errs, 0);
    check("leftover_expected", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Monitor: pop one prediction whenever the DUT shows owned activity.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (mon_en && ((grant != '0) || s_cyc || s_stb || (|m_ack) || (|m_err) || (|m_rty))) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output cycle=%0d got grant=%b exp idle", cycle, grant);
        end else begin
          e = q.pop_front();
          check("cycle_tag", cycle, e.tag);
          check("grant", grant, e.grant);
          check("slave_side", {s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel, s_cti, s_bte}, e.slv);
          check("responses", {m_ack, m_err, m_rty, m_dat_sm}, e.rsp);
        end
      end
    end
  end

endmodule
